// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the
// round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 4;
   localparam int DEF_CNT_WIDTH  = 16;

   // never narrower than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_ID_W   = idx_width(DEF_NUM_REQ);
   localparam int DEF_BCNT_W = idx_width(DEF_MAX_BURST);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first
// candidate at or after ptr_i, circularly.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic [N-1:0]  excl_i,
   output logic          pick_valid_o,
   output logic [IW-1:0] pick_id_o
);

   logic [N-1:0]   cand;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             off;
   int             sum;

   always_comb begin
      pick_valid_o = 1'b0;
      pick_id_o    = '0;
      off          = 0;
      sum          = 0;
      cand         = req_i & ~excl_i;
      // rot[k] is the candidate k places after ptr_i
      dbl          = {cand, cand} >> ptr_i;
      rot          = dbl[N-1:0];
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pick_valid_o = 1'b1;
            off          = k;
         end
      end
      sum = int'(ptr_i) + off;
      if (sum >= N) sum = sum - N;
      pick_id_o = IW'(sum);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO
// write port between NUM_REQ valid/ready producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = DEF_NUM_REQ,
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int MAX_BURST  = DEF_MAX_BURST,
   parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
   localparam int IdW        = idx_width(NUM_REQ),
   localparam int BcW        = idx_width(MAX_BURST)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic                          grant_valid,
   output logic [IdW-1:0]                grant_id,
   output logic [CNT_WIDTH-1:0]          beat_total
);

   arb_state_e           state_q;
   logic [IdW-1:0]       gid_q;
   logic [IdW-1:0]       ptr_q;
   logic [BcW-1:0]       bcnt_q;
   logic [CNT_WIDTH-1:0] total_q;

   logic [DATA_WIDTH-1:0] words [NUM_REQ];
   logic                  owner_v;
   logic                  accept;
   logic                  last_beat;
   logic                  drop;
   logic                  rel;
   logic [IdW-1:0]        gid_inc;
   logic [IdW-1:0]        pk_ptr;
   logic [NUM_REQ-1:0]    pk_excl;
   logic                  pk_valid;
   logic [IdW-1:0]        pk_id;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
      assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign owner_v   = req_valid[gid_q];
   assign accept    = (state_q == GRANT) && owner_v
                      && !fifo_full;
   assign last_beat = accept
                      && (bcnt_q == BcW'(MAX_BURST - 1));
   assign drop      = (state_q == GRANT) && !owner_v;
   assign rel       = last_beat || drop;

   assign gid_inc = (gid_q == IdW'(NUM_REQ - 1))
                    ? '0 : gid_q + 1'b1;
   // re-pick on release uses the advanced pointer
   assign pk_ptr  = rel ? gid_inc : ptr_q;
   assign pk_excl = drop ? (NUM_REQ'(1) << gid_q) : '0;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IdW)
   ) u_pick (
      .req_i        (req_valid),
      .ptr_i        (pk_ptr),
      .excl_i       (pk_excl),
      .pick_valid_o (pk_valid),
      .pick_id_o    (pk_id)
   );

   always_comb begin
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_data_in = '0;
      if (rst_n) begin
         fifo_wr_en       = accept;
         req_ready[gid_q] = accept;
         if (state_q == GRANT) fifo_data_in = words[gid_q];
      end
   end

   assign grant_valid = (state_q == GRANT);
   assign grant_id    = gid_q;
   assign beat_total  = total_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gid_q   <= '0;
         ptr_q   <= '0;
         bcnt_q  <= '0;
         total_q <= '0;
      end else begin
         if (accept) total_q <= total_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               if (pk_valid) begin
                  state_q <= GRANT;
                  gid_q   <= pk_id;
               end
            end
            GRANT: begin
               if (rel) begin
                  ptr_q  <= gid_inc;
                  bcnt_q <= '0;
                  if (pk_valid) gid_q <= pk_id;
                  else state_q <= IDLE;
               end else if (accept) begin
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter
// against a transaction-level reference model.
module tb_fifo_wr_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int MB    = 4;
   localparam int CW    = 16;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             fifo_wr_en;
   logic [DW-1:0]    fifo_data_in;
   logic             fifo_full;
   logic             grant_valid;
   logic [1:0]       grant_id;
   logic [CW-1:0]    beat_total;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .fifo_full    (fifo_full),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id),
      .beat_total   (beat_total)
   );

   int n_tot = 0;
   int n_bad = 0;

   logic [DW-1:0] pdata [NR];
   int            rem [NR];
   bit            rand_mode;
   int            rd_mode;
   logic [NR-1:0] v;
   bit            rd;
   int            fcnt;
   int            cyc;

   int            m_own;
   int            m_id;
   int            m_rr;
   int            m_beats;
   int unsigned   m_total;
   bit            e_acc;
   int            acc_id;

   int            wr_log [$];
   int            id_log [$];
   int            wc_log [$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input int start,
                               input logic [NR-1:0] vv,
                               input int excl);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (start + k) % NR;
         if (vv[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_own   = -1;
      m_id    = 0;
      m_rr    = 0;
      m_beats = 0;
      m_total = 0;
   endtask

   task automatic clear_logs();
      wr_log.delete();
      id_log.delete();
      wc_log.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (rand_mode) begin
            if (v[i]) v[i] = ($urandom_range(0, 99) < 85);
            else      v[i] = ($urandom_range(0, 99) < 30);
         end else begin
            v[i] = (rem[i] > 0);
         end
         req_data[i*DW +: DW] = pdata[i];
      end
      req_valid = v;
      rd = (rd_mode == 1)
           || (rd_mode == 2 && $urandom_range(0, 1) == 1);
      fifo_full = (fcnt >= DEPTH);
   endtask

   task automatic check_step();
      logic [NR-1:0] exp_rdy;
      logic [DW-1:0] exp_d;
      int            ex;
      bit            dropped;
      e_acc   = rst_n && m_own >= 0 && v[m_own] && !fifo_full;
      acc_id  = m_own;
      exp_rdy = e_acc ? (NR'(1) << m_own) : '0;
      exp_d   = (m_own >= 0) ? pdata[m_own] : '0;
      chk("grant_valid", 32'(grant_valid), 32'(m_own >= 0));
      chk("grant_id", 32'(grant_id), 32'(m_id));
      chk("wr_en", 32'(fifo_wr_en), 32'(e_acc));
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("data_in", 32'(fifo_data_in), 32'(exp_d));
      chk("beat_total", 32'(beat_total), m_total & 32'hFFFF);
      if (fifo_wr_en) begin
         wr_log.push_back(int'(fifo_data_in));
         id_log.push_back(int'(grant_id));
         wc_log.push_back(cyc);
      end
      if (!rst_n) return;
      if (m_own < 0) begin
         ex = pick(m_rr, v, -1);
         if (ex >= 0) begin
            m_own   = ex;
            m_id    = ex;
            m_beats = 0;
         end
      end else begin
         dropped = !v[m_own];
         if (e_acc) begin
            m_beats++;
            m_total++;
         end
         if (dropped || m_beats == MB) begin
            m_rr    = (m_own + 1) % NR;
            ex      = pick(m_rr, v, dropped ? m_own : -1);
            m_beats = 0;
            m_own   = ex;
            if (ex >= 0) m_id = ex;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      check_step();
      @(posedge clk);
      cyc++;
      if (rd && fcnt > 0) fcnt--;
      if (e_acc) begin
         fcnt++;
         pdata[acc_id] = pdata[acc_id] + 8'd1;
         if (!rand_mode) rem[acc_id]--;
      end
   endtask

   // async assert between edges, hold 3 cycles, release
   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_gv", 32'(grant_valid), 32'd0);
      chk("rst_wr", 32'(fifo_wr_en), 32'd0);
      chk("rst_rdy", 32'(req_ready), 32'd0);
      chk("rst_data", 32'(fifo_data_in), 32'd0);
      chk("rst_total", 32'(beat_total), 32'd0);
      m_reset();
      rand_mode = 1'b0;
      for (int i = 0; i < NR; i++) rem[i] = 0;
      repeat (3) cycle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      v         = '0;
      rand_mode = 1'b0;
      rd_mode   = 0;
      fcnt      = 0;
      cyc       = 0;
      for (int i = 0; i < NR; i++) begin
         pdata[i] = '0;
         rem[i]   = 0;
      end
      m_reset();

      // reset and idle
      repeat (3) cycle();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle();

      // single requester, burst boundary without bubble
      reset_mid();
      fcnt = 0;
      rd_mode = 1;
      pdata[1] = 8'h10;
      rem[1] = 6;
      clear_logs();
      repeat (9) cycle();
      chk("single_n", 32'(wr_log.size()), 32'd6);
      for (int k = 0; k < 6 && k < wr_log.size(); k++)
         chk("single_dat", 32'(wr_log[k]), 32'h10 + 32'(k));
      if (wc_log.size() == 6)
         chk("single_gap", 32'(wc_log[5] - wc_log[0]), 32'd5);
      chk("single_total", 32'(beat_total), 32'd6);

      // fairness with all requesters valid
      reset_mid();
      fcnt = 0;
      rd_mode = 1;
      for (int i = 0; i < NR; i++) begin
         pdata[i] = 8'h40 + 8'(i);
         rem[i] = 1000;
      end
      clear_logs();
      repeat (19) cycle();
      chk("fair_n", 32'(id_log.size() >= 17), 32'd1);
      for (int k = 0; k < 17 && k < id_log.size(); k++)
         chk("fair_id", 32'(id_log[k]), 32'((k / 4) % 4));

      // full stall then one read
      reset_mid();
      fcnt = 0;
      rd_mode = 0;
      rem[0] = 20;
      rem[2] = 20;
      clear_logs();
      repeat (12) cycle();
      chk("full_n", 32'(wr_log.size()), 32'd8);
      rd_mode = 1;
      cycle();
      rd_mode = 0;
      repeat (6) cycle();
      chk("full_n2", 32'(wr_log.size()), 32'd9);

      // partial burst handover
      reset_mid();
      fcnt = 0;
      rd_mode = 1;
      pdata[2] = 8'hA0;
      rem[2] = 2;
      pdata[3] = 8'hB0;
      rem[3] = 3;
      clear_logs();
      repeat (9) cycle();
      chk("part_n", 32'(wr_log.size()), 32'd5);
      if (wr_log.size() == 5) begin
         chk("part_d0", 32'(wr_log[0]), 32'hA0);
         chk("part_d1", 32'(wr_log[1]), 32'hA1);
         chk("part_d2", 32'(wr_log[2]), 32'hB0);
         chk("part_d4", 32'(wr_log[4]), 32'hB2);
      end

      // reset in the middle of a burst
      reset_mid();
      fcnt = 0;
      rd_mode = 1;
      pdata[1] = 8'h60;
      rem[1] = 10;
      repeat (3) cycle();
      reset_mid();
      rem[0] = 3;
      rem[1] = 3;
      clear_logs();
      repeat (8) cycle();
      chk("mid_n", 32'(id_log.size()), 32'd6);
      if (id_log.size() > 0)
         chk("mid_first", 32'(id_log[0]), 32'd0);

      // randomized traffic
      reset_mid();
      fcnt = 0;
      for (int i = 0; i < NR; i++)
         pdata[i] = 8'($urandom_range(0, 255));
      rand_mode = 1'b1;
      repeat (8) begin
         rd_mode = int'($urandom_range(0, 2));
         repeat (400) cycle();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo write port between NUM_REQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats.
- It drives the FIFO's wr_en/data_in and honours fifo_full.
- It sits between producer blocks and the FIFO input and also provides a grant-status readback.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO word width.
- MAX_BURST, 4, maximum beats per grant before re-arbitration (1..16).
- CNT_WIDTH, 16, width of the accepted-beat statistics counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester data-valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat-accepted strobe.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_data_in  out  DATA_WIDTH  to FIFO data_in.
- fifo_full  in  1  from FIFO full flag.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  clog2(NUM_REQ)  index of the owner.
- beat_total  out  CNT_WIDTH  count of accepted beats; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; grant_valid=0; grant_id=0; rr pointer=0 (requester 0 highest priority).
  - beat counter=0; beat_total=0.
  - req_ready=0; fifo_wr_en=0; fifo_data_in=0 (combinational outputs forced low while rst_n=0).
- States:
  - IDLE: no owner.
  - GRANT: owner = grant_id.
- Arbitration:
  - Pick = first asserted req_valid, searching circularly from rr pointer.
  - The pick is registered, so the grant appears the cycle after valid is first seen. Arbitration latency from IDLE is 1 cycle.
- Accept (combinational from registered grant):
  - accept = state==GRANT && req_valid[grant_id] && !fifo_full.
  - fifo_wr_en = accept.
  - fifo_data_in = req_data slice of grant_id when grant_valid, else 0.
  - req_ready[grant_id] = accept; all other req_ready bits are 0.
- Beat handling:
  - Each accept increments the beat counter and beat_total.
  - Producers hold data stable while valid && !ready.
- Release conditions (evaluated each cycle in GRANT):
  - (a) accept with beat counter == MAX_BURST-1, or
  - (b) req_valid[grant_id]==0.
- On release:
  - rr pointer = grant_id+1 mod NUM_REQ; beat counter cleared.
  - A new pick is made in the same cycle using the updated pointer and current req_valid, excluding the owner only in case (b).
  - If a pick exists, next state=GRANT with the new grant_id: no bubble between bursts. Otherwise next state=IDLE.
  - In case (a), if only the owner is valid, it is re-granted immediately for a fresh burst.
- fifo_full in GRANT:
  - No accept; beat counter frozen; grant held indefinitely. There is no timeout.
  - Accepts resume the cycle fifo_full deasserts.
- Valid drop: a dropped valid with no accept that cycle releases per (b). Partial bursts are legal.
- grant_valid = (state==GRANT); grant_id holds its last value in IDLE.
- Reset mid-burst: all state is cleared immediately. Partial burst data already written stays in the FIFO; no replay.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding (IDLE=0, GRANT=1);
  - clog2-derived width constants for grant_id and the beat counter;
  - default parameter values.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, pointer, exclude mask.
  - Outputs: pick_valid, pick_id.
- The top level holds the FSM, counters and output muxing.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4, FIFO depth 8, FIFO read idle unless stated):
1. Reset: rst_n=0 for 3 cycles, then 1, no requests -> fifo_wr_en=0, req_ready=0000, grant_valid=0, beat_total=0 throughout; rst_n low mid-cycle clears outputs without waiting for clk.
2. Single requester: req 1 streams 0x10..0x15 continuously -> grant_id=1 one cycle after valid. FIFO receives 0x10..0x15 on 6 consecutive cycles with no bubble at the burst-4 boundary (re-grant to 1). beat_total=6.
3. Fairness: all 4 valid continuously, data = 0x40+i per requester, FIFO drained every cycle -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; req_ready is one-hot and matches grant_id.
4. Full stall: req 0 and req 2 valid, FIFO read idle -> 8 writes then fifo_full=1; fifo_wr_en=0 and req_ready=0000 while full; grant_id and beat counter frozen. One FIFO read -> exactly one further accept, then stall again.
5. Partial burst: req 2 sends 0xA0,0xA1 then drops valid while req 3 is valid -> grant moves to 3 the next cycle; FIFO order is 0xA0,0xA1, then req 3 data; rr pointer=3 afterwards.
6. Reset mid-burst: req 1 granted, 2 beats accepted, rst_n pulsed low -> grant_valid=0 immediately. After release with reqs 0 and 1 valid, req 0 is granted first (pointer reset) and beat_total restarts from 0.
